// File: rtl/m_ext_seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Latency: 34 cycles start-edge to done (2 cycles for div-by-zero/overflow when DIV_SPECIAL_BYPASS_EN is defined).
// Backpressure: none; start is taken only in IDLE, ignored while busy, and abort kills the in-flight op.
//
// Optional feature macro: DIV_SPECIAL_BYPASS_EN (skip CALC for divide-by-zero and signed overflow).
//
// Ports:
//   clk, rst_n         : rising-edge clock, asynchronous active-low reset
//   start, op          : request and opcode (00 DIV, 01 DIVU, 10 REM, 11 REMU = funct3[1:0])
//   dividend, divisor  : rs1 / rs2, sampled with start
//   abort              : pipeline flush, drops the in-flight operation without done
//   busy               : high while an operation is in flight
//   done               : one-cycle pulse when result is updated
//   result             : quotient or remainder, held until the next done
module m_ext_seq_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;      // divisor magnitude
  logic [XLEN-1:0]   a_q, a_d;          // original dividend, returned as remainder on divide-by-zero
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  // Request decode, only meaningful in IDLE.
  logic            in_signed;
  logic            sign_a;
  logic            sign_b;
  logic            in_div0;
  logic            in_ovf;

  assign in_signed = ~op[0];
  assign sign_a    = in_signed & dividend[XLEN-1];
  assign sign_b    = in_signed & divisor[XLEN-1];
  assign in_div0   = (divisor == '0);
  assign in_ovf    = in_signed && (dividend == INT_MIN) && (divisor == '1);

  // One restoring step. The shifted partial remainder needs XLEN+1 bits
  // because the divisor magnitude can exceed 2^(XLEN-1); the subtraction
  // result is always below the divisor and so fits back into XLEN bits.
  logic [XLEN:0]   rem_sh;
  logic            step_ge;

  assign rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign step_ge = (rem_sh >= {1'b0, dvs_q});

  // Sign-corrected results, with special cases taking priority.
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  always_comb begin
    q_fix = neg_quo_q ? -quo_q : quo_q;
    r_fix = neg_rem_q ? -rem_q : rem_q;
    if (div0_q) begin
      q_fix = '1;
      r_fix = a_q;
    end else if (ovf_q) begin
      q_fix = INT_MIN;
      r_fix = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    a_d       = a_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort has no meaning here; start always wins.
        if (start) begin
          op_d      = op;
          a_d       = dividend;
          quo_d     = sign_a ? -dividend : dividend;
          rem_d     = '0;
          dvs_d     = sign_b ? -divisor : divisor;
          neg_quo_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          div0_d    = in_div0;
          ovf_d     = in_ovf;
          cnt_d     = CNT_W'(XLEN - 1);
`ifdef DIV_SPECIAL_BYPASS_EN
          // Special results come entirely from the flags in FIX.
          state_d   = (in_div0 || in_ovf) ? S_FIX : S_CALC;
`else
          state_d   = S_CALC;
`endif
        end
      end

      S_CALC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_ge ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], step_ge};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          result_d = op_q[1] ? r_fix : q_fix;
          done_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      a_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      a_q       <= a_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_m_ext_seq_divider.sv
// Self-checking bench for m_ext_seq_divider: directed vectors feed a scoreboard,
// a negedge monitor compares result and done cycle on every done pulse.
module tb_m_ext_seq_divider;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam int LAT_N = 34;
`ifdef DIV_SPECIAL_BYPASS_EN
  localparam int LAT_S = 2;
`else
  localparam int LAT_S = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          edge_cnt = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  logic [31:0] last_res = '0;

  m_ext_seq_divider #(.XLEN(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got result 0x%08h, expected no done (t=%0t)", result, $time);
      end else begin
        logic [31:0] e;
        int          c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        chk("result", result, e);
        chk("done_cycle", 32'(edge_cnt), 32'(c));
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge (edge T).
  // On return the bench sits at the negedge of cycle T+1 with start low.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    if (push) begin
      exp_q.push_back(exp);
      cyc_q.push_back(edge_cnt + lat);
      last_res = exp;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done within 60 cycles, expected a done pulse (t=%0t)", $time);
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    issue(o, a, b, exp, lat, 1'b1);
    wait_done();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    // Reset state.
    idle_cycles(2);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // DIVU 100/7 with busy window, then REMU started in the done cycle.
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_N, 1'b1);
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      if (busy !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("busy_window_gaps", 32'(bad), 32'd0);
    chk("busy_in_done_cycle", {31'd0, busy}, 32'd0);
    chk("done_at_T34", {31'd0, done}, 32'd1);
    run(OP_REMU, 32'd100, 32'd7, 32'd2, LAT_N);

    // Signed cases.
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_N);
    run(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_N);
    run(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_N);
    run(OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, LAT_N);
    run(OP_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4, LAT_N);

    // Large unsigned operands.
    run(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, LAT_N);
    run(OP_REMU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, LAT_N);
    run(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, LAT_N);
    run(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, LAT_N);

    // Divide by zero.
    run(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_S);
    run(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_S);
    run(OP_REM, 32'd5, 32'd0, 32'd5, LAT_S);
    run(OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, LAT_S);
    run(OP_REMU, 32'd5, 32'd0, 32'd5, LAT_S);

    // Signed overflow.
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_S);
    run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_S);
    run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_N);

    // Abort at T+10 of DIVU 1000/3.
    @(negedge clk);
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, LAT_N, 1'b0);
    idle_cycles(9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result_kept", result, last_res);
    idle_cycles(40);
    chk("abort_result_later", result, last_res);
    run(OP_DIVU, 32'd1000, 32'd3, 32'd333, LAT_N);

    // abort and start in the same IDLE cycle: start wins.
    @(negedge clk);
    abort = 1'b1;
    issue(OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_N, 1'b1);
    abort = 1'b0;
    wait_done();

    // start held high while busy is ignored.
    @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_N, 1'b1);
    start    = 1'b1;
    op       = OP_DIVU;
    dividend = 32'd50;
    divisor  = 32'd5;
    idle_cycles(20);
    start = 1'b0;
    wait_done();
    idle_cycles(40);

    // Reset at T+20 of an operation.
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, LAT_N, 1'b0);
    idle_cycles(19);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(40);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    run(OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_N);
    idle_cycles(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/m_ext_seq_divider.md
Name: m_ext_seq_divider

Overview:
- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Counterpart to the Wallace-tree/4:2-compressor multiply path: the multiplier reduces partial products; this block reconstructs a quotient from a product-like dividend.
- Sits in the EX stage beside the multiplier.
- Uses a start/busy/done handshake so the pipeline stalls while busy.

Parameters:
- XLEN, 32, operand and result width; only 32 is verified.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (equals funct3[1:0])
- dividend  input  XLEN  rs1 value, sampled with start
- divisor  input  XLEN  rs2 value, sampled with start
- abort  input  1  pipeline flush; kills the in-flight operation
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when result becomes valid
- result  output  XLEN  quotient or remainder per latched op; held until next done

Behaviour:
- Reset (rst_n=0, async): state=IDLE, busy=0, done=0, result=0, all internal registers cleared.
- Reset mid-operation: the operation is discarded and no done is produced.
- States:
  - IDLE: start=1 at edge T latches op and the operands. Signed ops latch magnitudes plus sign flags (quotient negate = sign(a) xor sign(b); remainder negate = sign(a)). Next state CALC, counter=XLEN-1.
  - CALC: one restoring step per cycle. {rem, quo} shifts left 1. If rem >= divisor magnitude, subtract it and set quo LSB. Counter decrements. After the step with counter=0, go to FIX.
  - FIX: apply sign correction; select quo (op[1]=0) or rem (op[1]=1); register into result. Next state IDLE.
- Timing:
  - busy=1 for cycles T+1..T+33.
  - done=1 and new result visible in cycle T+34 only; busy=0 in that cycle.
  - Normal latency: 34 cycles from start edge to done.
- In IDLE, busy=0. start while busy is ignored; no queueing.
- start in the same cycle done=1 is accepted; back-to-back throughput is one op per 34 cycles.
- abort while busy: return to IDLE at the next edge; busy=0 next cycle; no done; result unchanged. abort in IDLE has no effect. abort and start in the same IDLE cycle: start wins.
- Divide by zero (divisor==0), all ops, no sign correction applied:
  - quotient = all ones (DIV returns -1, DIVU returns 0xFFFFFFFF);
  - remainder = original dividend.
- Signed overflow (DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- The magnitude of 0x80000000 is 0x80000000 treated as unsigned; no 33-bit datapath is needed.
- Remainder sign always follows the dividend; a zero remainder is never negated.

Optional Feature:
- Macro: DIV_SPECIAL_BYPASS_EN.
- Defined: divide-by-zero and signed overflow are detected in IDLE at start. The block goes straight to FIX with the special result preloaded. busy=1 in T+1 only; done in T+2.
- Undefined: special cases run the full CALC/FIX sequence (done at T+34). FIX overrides the result with the special-case value.
- Results are bit-identical either way; only latency differs.

Test Plan:
- DIVU 100/7 then REMU 100/7 -> result 14, then 2; done exactly at T+34; busy high T+1..T+33.
- DIV -7/2, REM -7/2, DIV 7/-2 -> 0xFFFFFFFD (-3), 0xFFFFFFFF (-1), 0xFFFFFFFD (-3).
- DIV 5/0, DIVU 5/0, REM 5/0 -> 0xFFFFFFFF, 0xFFFFFFFF, 5. Done at T+2 with DIV_SPECIAL_BYPASS_EN, else T+34.
- DIV 0x80000000/0xFFFFFFFF and REM of same -> 0x80000000 and 0.
- abort asserted at T+10 during DIVU 1000/3 -> no done, busy=0 at T+11, result keeps prior value. Then start DIVU 1000/3 -> 333.
- rst_n pulled low at T+20 of an operation -> busy, done, result all 0 immediately; no done after release. Also: start held high during busy is ignored; start coincident with done is accepted.
